// File: rtl/mpi_pkg.sv
// ============================================================
// Module : mpi_pkg -- shared constants and FSM encoding for the uP bridge
// Rev    : 1.0
// ============================================================
`default_nettype none

package mpi_pkg;

  localparam int C_DATA_W      = 8;
  localparam int C_ADDR_W      = 6;
  localparam int C_SYNC_STAGES = 2;
  localparam int C_TIMEOUT     = 15;
  localparam logic [C_DATA_W-1:0] C_ERR_DATA = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mpi_cs_sync.sv
// ============================================================
// Module : mpi_cs_sync -- chip-select synchroniser and access-start detector
// Rev    : 1.0
// ============================================================
`default_nettype none

module mpi_cs_sync
  import mpi_pkg::*;
#(
  parameter int SYNC_STAGES = C_SYNC_STAGES
) (
  input  logic Clock,
  input  logic Rst_n,
  input  logic cs_n,
  output logic cs_sync,
  output logic start
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_vld;
  logic                   r_pipe;
  logic                   r_armed;

  // r_vld marks when the chain holds real pin samples rather than reset
  // values, so a select held low across reset is never taken as a new start.
  always_ff @(posedge Clock or negedge Rst_n) begin
    if (!Rst_n) begin
      r_sync  <= '1;
      r_vld   <= '0;
      r_pipe  <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], cs_n};
      r_vld  <= {r_vld[SYNC_STAGES-2:0], 1'b1};
      r_pipe <= r_sync[SYNC_STAGES-1];
      if (r_vld[SYNC_STAGES-1] && r_sync[SYNC_STAGES-1]) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign cs_sync = r_sync[SYNC_STAGES-1];
  assign start   = r_armed & ~cs_sync & r_pipe;

endmodule

`default_nettype wire

// File: rtl/mpi_bridge.sv
// ============================================================
// Module : mpi_bridge -- asynchronous uP port to local req/ack bus bridge
// Rev    : 1.0
// ============================================================
`default_nettype none

module mpi_bridge
  import mpi_pkg::*;
#(
  parameter int                DATA_W      = C_DATA_W,
  parameter int                ADDR_W      = C_ADDR_W,
  parameter int                DEPTH       = 48,
  parameter int                SYNC_STAGES = C_SYNC_STAGES,
  parameter int                TIMEOUT     = C_TIMEOUT,
  parameter logic [DATA_W-1:0] ERR_DATA    = {DATA_W{C_ERR_DATA[0]}}
) (
  input  logic              Clock,
  input  logic              Rst_n,
  inout  wire  [DATA_W-1:0] Mpi_data,
  input  logic [ADDR_W-1:0] Mpi_addr,
  input  logic              Mpi_cs_n,
  input  logic              Mpi_rw,
  output logic              Mpi_rdy_n,
  output logic              Mpi_err,
  output logic              Loc_req,
  output logic              Loc_we,
  output logic [ADDR_W-1:0] Loc_addr,
  output logic [DATA_W-1:0] Loc_wdata,
  input  logic [DATA_W-1:0] Loc_rdata,
  input  logic              Loc_ack
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_loc_addr;
  logic [DATA_W-1:0]   r_loc_wdata;
  logic                r_loc_we;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [TMO_W-1:0]    r_tmo_cnt;

  logic w_cs_sync;
  logic w_start;
  logic w_addr_bad;
  logic w_capture;
  logic w_done_ok;
  logic w_done_fail;

  mpi_cs_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cs_sync (
    .Clock   (Clock),
    .Rst_n   (Rst_n),
    .cs_n    (Mpi_cs_n),
    .cs_sync (w_cs_sync),
    .start   (w_start)
  );

  assign w_addr_bad = (32'(Mpi_addr) >= 32'(DEPTH));

  always_ff @(posedge Clock or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_done_ok   = 1'b0;
    w_done_fail = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_capture = 1'b1;
          if (w_addr_bad) begin
            w_done_fail = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (Loc_ack) begin
          w_done_ok   = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          w_done_fail = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_cs_sync) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Error flag and read data only change on DONE entry; a chip-select
  // release mid-REQ still lets the local access run to completion.
  always_ff @(posedge Clock or negedge Rst_n) begin
    if (!Rst_n) begin
      r_loc_addr  <= '0;
      r_loc_wdata <= '0;
      r_loc_we    <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      if (w_capture) begin
        r_loc_addr  <= Mpi_addr;
        r_loc_wdata <= Mpi_data;
        r_loc_we    <= ~Mpi_rw;
        r_tmo_cnt   <= '0;
      end else if (r_state == ST_REQ && r_tmo_cnt != TMO_W'(TIMEOUT)) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (w_done_ok) begin
        r_err <= 1'b0;
        if (!r_loc_we) begin
          r_rdata <= Loc_rdata;
        end
      end else if (w_done_fail) begin
        r_err   <= 1'b1;
        r_rdata <= ERR_DATA;
      end
    end
  end

  assign Loc_req   = (r_state == ST_REQ);
  assign Loc_we    = r_loc_we;
  assign Loc_addr  = r_loc_addr;
  assign Loc_wdata = r_loc_wdata;
  assign Mpi_err   = r_err;
  assign Mpi_rdy_n = ~((r_state == ST_DONE) && !w_cs_sync);

  assign Mpi_data = (!Mpi_cs_n && Mpi_rw) ? r_rdata : {DATA_W{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_mpi_bridge.sv
// ============================================================
// Module : tb_mpi_bridge -- directed self-checking bench for mpi_bridge
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_mpi_bridge;

  logic       Clock = 1'b0;
  logic       Rst_n;
  logic       Mpi_cs_n;
  logic       Mpi_rw;
  logic [5:0] Mpi_addr;
  logic       Loc_ack;
  logic [7:0] Loc_rdata;
  logic [7:0] tb_drv;
  logic       tb_oe;

  wire  [7:0] Mpi_data;
  wire        Mpi_rdy_n;
  wire        Mpi_err;
  wire        Loc_req;
  wire        Loc_we;
  wire  [5:0] Loc_addr;
  wire  [7:0] Loc_wdata;

  int total = 0;
  int bad   = 0;
  int cnt;

  always #5 Clock = ~Clock;

  assign Mpi_data = tb_oe ? tb_drv : 8'hzz;

  // A released bus reads back as 0x00 through the pulldowns.
  for (genvar i = 0; i < 8; i++) begin : g_pd
    pulldown (Mpi_data[i]);
  end

  mpi_bridge dut (
    .Clock     (Clock),
    .Rst_n     (Rst_n),
    .Mpi_data  (Mpi_data),
    .Mpi_addr  (Mpi_addr),
    .Mpi_cs_n  (Mpi_cs_n),
    .Mpi_rw    (Mpi_rw),
    .Mpi_rdy_n (Mpi_rdy_n),
    .Mpi_err   (Mpi_err),
    .Loc_req   (Loc_req),
    .Loc_we    (Loc_we),
    .Loc_addr  (Loc_addr),
    .Loc_wdata (Loc_wdata),
    .Loc_rdata (Loc_rdata),
    .Loc_ack   (Loc_ack)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic start_cs(input logic [5:0] addr, input logic rw, input logic [7:0] data);
    Mpi_addr = addr;
    Mpi_rw   = rw;
    tb_drv   = data;
    tb_oe    = ~rw;
    Mpi_cs_n = 1'b0;
  endtask

  task automatic release_cs();
    Mpi_cs_n = 1'b1;
    tb_oe    = 1'b0;
  endtask

  task automatic pulse_ack(input logic [7:0] rdata);
    Loc_ack   = 1'b1;
    Loc_rdata = rdata;
    tick();
    Loc_ack   = 1'b0;
    Loc_rdata = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Rst_n = 1'b0; Mpi_cs_n = 1'b1; Mpi_rw = 1'b1; Mpi_addr = '0;
    tb_drv = '0; tb_oe = 1'b0; Loc_ack = 1'b0; Loc_rdata = '0;
    tick(2);
    check_eq("rst_req",   Loc_req,   0);
    check_eq("rst_we",    Loc_we,    0);
    check_eq("rst_addr",  Loc_addr,  0);
    check_eq("rst_wdata", Loc_wdata, 0);
    check_eq("rst_err",   Mpi_err,   0);
    check_eq("rst_rdy",   Mpi_rdy_n, 1);
    check_eq("rst_bus",   Mpi_data,  8'h00);
    Rst_n = 1'b1;
    tick(5);

    // write 0x05 <- 0xA5
    start_cs(6'h05, 1'b0, 8'hA5);
    tick(); check_eq("wr_req_e1", Loc_req, 0);
    tick(); check_eq("wr_req_e2", Loc_req, 0);
    tick(); check_eq("wr_req_e3", Loc_req, 1);
    check_eq("wr_we",    Loc_we,    1);
    check_eq("wr_addr",  Loc_addr,  6'h05);
    check_eq("wr_wdata", Loc_wdata, 8'hA5);
    tick();
    check_eq("wr_hold_req",  Loc_req,   1);
    check_eq("wr_hold_data", Loc_wdata, 8'hA5);
    pulse_ack(8'h00);
    check_eq("wr_done_req", Loc_req,   0);
    check_eq("wr_rdy",      Mpi_rdy_n, 0);
    check_eq("wr_err",      Mpi_err,   0);
    tick(4);
    check_eq("wr_rdy_hold", Mpi_rdy_n, 0);
    release_cs();
    tick(3);
    check_eq("wr_rdy_rel", Mpi_rdy_n, 1);
    tick();

    // read 0x10 -> 0x3C
    start_cs(6'h10, 1'b1, 8'h00);
    tick(3);
    check_eq("rd_req",  Loc_req,  1);
    check_eq("rd_we",   Loc_we,   0);
    check_eq("rd_addr", Loc_addr, 6'h10);
    pulse_ack(8'h3C);
    check_eq("rd_rdy",  Mpi_rdy_n, 0);
    check_eq("rd_err",  Mpi_err,   0);
    check_eq("rd_data", Mpi_data,  8'h3C);
    release_cs();
    #1 check_eq("rd_hiz", Mpi_data, 8'h00);
    tick(3);

    // stray ack while idle must not disturb anything
    pulse_ack(8'h55);
    check_eq("ign_req", Loc_req,   0);
    check_eq("ign_rdy", Mpi_rdy_n, 1);

    // out-of-range address 0x30
    start_cs(6'h30, 1'b1, 8'h00);
    #1 check_eq("ign_rdata", Mpi_data, 8'h3C);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (Loc_req) cnt++;
    end
    check_eq("bad_noreq", cnt,       0);
    check_eq("bad_rdy",   Mpi_rdy_n, 0);
    check_eq("bad_err",   Mpi_err,   1);
    check_eq("bad_data",  Mpi_data,  8'hFF);
    release_cs();
    tick(4);

    // no ack: request must last exactly 15 cycles
    start_cs(6'h01, 1'b1, 8'h00);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Loc_req) cnt++;
      else if (cnt > 0) break;
    end
    check_eq("tmo_len",  cnt,       15);
    check_eq("tmo_err",  Mpi_err,   1);
    check_eq("tmo_rdy",  Mpi_rdy_n, 0);
    check_eq("tmo_data", Mpi_data,  8'hFF);
    release_cs();
    tick(4);

    // reset pulse in the middle of a request, select held low throughout
    start_cs(6'h03, 1'b0, 8'h44);
    tick(3);
    check_eq("mr_req_pre", Loc_req, 1);
    #2 Rst_n = 1'b0;
    #1;
    check_eq("mr_req",   Loc_req,   0);
    check_eq("mr_err",   Mpi_err,   0);
    check_eq("mr_addr",  Loc_addr,  0);
    check_eq("mr_wdata", Loc_wdata, 0);
    check_eq("mr_we",    Loc_we,    0);
    check_eq("mr_rdy",   Mpi_rdy_n, 1);
    tick(2);
    Rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Loc_req || !Mpi_rdy_n) cnt++;
    end
    check_eq("mr_no_spur", cnt, 0);
    release_cs();
    tick(5);

    // select released while the local access is outstanding
    start_cs(6'h02, 1'b0, 8'h11);
    tick(3);
    check_eq("cr_req", Loc_req, 1);
    release_cs();
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (!Mpi_rdy_n) cnt++;
    end
    pulse_ack(8'h00);
    if (!Mpi_rdy_n) cnt++;
    check_eq("cr_done_req", Loc_req, 0);
    tick();
    if (!Mpi_rdy_n) cnt++;
    check_eq("cr_rdy_never", cnt,     0);
    check_eq("cr_err",       Mpi_err, 0);
    tick(2);

    // following access behaves normally
    start_cs(6'h07, 1'b0, 8'h99);
    tick(2); check_eq("nx_req_e2", Loc_req, 0);
    tick();  check_eq("nx_req_e3", Loc_req, 1);
    check_eq("nx_addr",  Loc_addr,  6'h07);
    check_eq("nx_wdata", Loc_wdata, 8'h99);
    pulse_ack(8'h00);
    check_eq("nx_rdy", Mpi_rdy_n, 0);
    check_eq("nx_err", Mpi_err,   0);
    release_cs();
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
